// File: rtl/sonic_vc_pkg.sv
// rtl/sonic_vc_pkg.sv - shared types and widths for the sonic virtual-channel TX/RX path
package sonic_vc_pkg;

    localparam int SONIC_VC_DW = 64;

    typedef enum logic {VC_IDLE, VC_LOCK} vc_arb_state_t;

endpackage

// File: rtl/sonic_rr_pick.sv
// rtl/sonic_rr_pick.sv - combinational round-robin picker: first unmasked request at or after start
module sonic_rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0]   elig;
    logic [2*N-1:0] rot;
    int             sum;

    assign elig = req & ~mask;
    // start is always < N, so the doubled vector shifted by start holds one full rotation
    assign rot  = {elig, elig} >> start;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(start) + k;
                idx   = W'((sum >= N) ? (sum - N) : sum);
            end
        end
    end

endmodule

// File: rtl/sonic_vc_tx_arb.sv
// rtl/sonic_vc_tx_arb.sv - packet-granular round-robin merge of per-VC TLP streams onto the TX port
module sonic_vc_tx_arb
    import sonic_vc_pkg::*;
#(
    parameter int NUM_CHAN   = 2,
    parameter int DATA_WIDTH = SONIC_VC_DW,
    parameter int CHAN_WIDTH = $clog2(NUM_CHAN),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic [NUM_CHAN-1:0]            chan_valid,
    input  logic [NUM_CHAN-1:0]            chan_sop,
    input  logic [NUM_CHAN-1:0]            chan_eop,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] chan_data,
    output logic [NUM_CHAN-1:0]            chan_ready,
    output logic                           tx_st_valid,
    output logic                           tx_st_sop,
    output logic                           tx_st_eop,
    output logic [DATA_WIDTH-1:0]          tx_st_data,
    input  logic                           tx_st_ready,
    output logic [CHAN_WIDTH-1:0]          tx_chan,
    output logic                           err_stray,
    output logic [NUM_CHAN*CNT_WIDTH-1:0]  pkt_cnt
);

    vc_arb_state_t         state;
    logic [CHAN_WIDTH-1:0] grant;
    logic [CHAN_WIDTH-1:0] last_grant;
    logic [CNT_WIDTH-1:0]  cnt [NUM_CHAN];
    logic                  err_q;

    logic [NUM_CHAN-1:0]   req;
    logic [NUM_CHAN-1:0]   stray;
    logic [NUM_CHAN-1:0]   grant_oh;
    logic                  idle_found;
    logic                  eop_found;
    logic [CHAN_WIDTH-1:0] idle_idx;
    logic [CHAN_WIDTH-1:0] eop_idx;
    logic                  eop_acc;

    function automatic logic [CHAN_WIDTH-1:0] next_chan(input logic [CHAN_WIDTH-1:0] c);
        return (c == CHAN_WIDTH'(NUM_CHAN - 1)) ? '0 : c + CHAN_WIDTH'(1);
    endfunction

    assign req      = chan_valid & chan_sop;
    assign stray    = chan_valid & ~chan_sop;
    assign grant_oh = NUM_CHAN'(1) << grant;

    sonic_rr_pick #(.N(NUM_CHAN), .W(CHAN_WIDTH)) u_pick_idle (
        .req   (req),
        .mask  ('0),
        .start (next_chan(last_grant)),
        .found (idle_found),
        .idx   (idle_idx)
    );

    // The granted channel is masked so a back-to-back handoff always goes elsewhere
    sonic_rr_pick #(.N(NUM_CHAN), .W(CHAN_WIDTH)) u_pick_eop (
        .req   (req),
        .mask  (grant_oh),
        .start (next_chan(grant)),
        .found (eop_found),
        .idx   (eop_idx)
    );

    always_comb begin
        tx_st_valid = 1'b0;
        tx_st_sop   = 1'b0;
        tx_st_eop   = 1'b0;
        tx_st_data  = '0;
        chan_ready  = '0;
        tx_chan     = '0;
        if (!reset) begin
            if (state == VC_LOCK) begin
                tx_st_valid = chan_valid[grant];
                tx_st_sop   = chan_sop[grant];
                tx_st_eop   = chan_eop[grant];
                tx_st_data  = chan_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                chan_ready  = grant_oh & {NUM_CHAN{tx_st_ready}};
                tx_chan     = grant;
            end else begin
                chan_ready  = stray;
            end
        end
    end

    assign eop_acc   = tx_st_valid & tx_st_ready & tx_st_eop;
    assign err_stray = err_q & ~reset;

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = reset ? '0 : cnt[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= VC_IDLE;
            grant      <= '0;
            last_grant <= CHAN_WIDTH'(NUM_CHAN - 1);
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            err_q <= (state == VC_IDLE) && (|stray);
            case (state)
                VC_IDLE: begin
                    if (idle_found) begin
                        grant <= idle_idx;
                        state <= VC_LOCK;
                    end
                end
                VC_LOCK: begin
                    if (eop_acc) begin
                        cnt[grant] <= cnt[grant] + CNT_WIDTH'(1);
                        last_grant <= grant;
                        if (eop_found) begin
                            grant <= eop_idx;
                        end else begin
                            state <= VC_IDLE;
                        end
                    end
                end
                default: state <= VC_IDLE;
            endcase
        end
    end

endmodule
